// File: rtl/seq_alu_if.sv
// Operand/result bundle between the control sequencer and seq_alu.
interface seq_alu_if #(parameter int WIDTH = 16);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] ac;
    logic [WIDTH-1:0] dr;
    logic             e_in;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             e_out;
    logic             ovf;
    logic             n;
    logic             z;
    logic             busy;
    logic             done;

    modport master (
        output start, op, ac, dr, e_in,
        input  result, result_hi, e_out, ovf, n, z, busy, done
    );

    modport slave (
        input  start, op, ac, dr, e_in,
        output result, result_hi, e_out, ovf, n, z, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// Clocked accumulator ALU: single-cycle AC/DR/E ops plus WIDTH-cycle shift-add multiply.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    seq_alu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_AND = 3'b001, OP_LDA = 3'b010, OP_CMA = 3'b011,
        OP_CIR = 3'b100, OP_CIL = 3'b101, OP_INC = 3'b110, OP_MUL = 3'b111
    } op_e;

    typedef enum logic {IDLE, MUL_RUN} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               e_q, e_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               e_out_q, e_out_d;
    logic               ovf_q, ovf_d;
    logic               n_q, n_d;
    logic               z_q, z_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   res;
    logic               e_new;
    logic               ov;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_nx;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        e_d         = e_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        e_out_d     = e_out_q;
        ovf_d       = ovf_q;
        n_d         = n_q;
        z_d         = z_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        res         = '0;
        e_new       = bus.e_in;
        ov          = 1'b0;
        sum         = '0;
        prod_nx     = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (op_e'(bus.op) == OP_MUL) begin
                        state_d = MUL_RUN;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_INIT;
                        mcand_d = bus.ac;
                        prod_d  = {{WIDTH{1'b0}}, bus.dr};
                        e_d     = bus.e_in;
                    end else begin
                        case (op_e'(bus.op))
                            OP_ADD: begin
                                {e_new, res} = {1'b0, bus.ac} + {1'b0, bus.dr};
                                ov = (bus.ac[WIDTH-1] == bus.dr[WIDTH-1]) &&
                                     (res[WIDTH-1] != bus.ac[WIDTH-1]);
                            end
                            OP_AND: res = bus.ac & bus.dr;
                            OP_LDA: res = bus.dr;
                            OP_CMA: res = ~bus.ac;
                            OP_CIR: begin
                                res   = {bus.e_in, bus.ac[WIDTH-1:1]};
                                e_new = bus.ac[0];
                            end
                            OP_CIL: begin
                                res   = {bus.ac[WIDTH-2:0], bus.e_in};
                                e_new = bus.ac[WIDTH-1];
                            end
                            OP_INC: begin
                                {e_new, res} = {1'b0, bus.ac} + {{WIDTH{1'b0}}, 1'b1};
                                ov = (bus.ac == {1'b0, {(WIDTH-1){1'b1}}});
                            end
                            default: res = '0;
                        endcase
                        result_d    = res;
                        result_hi_d = '0;
                        e_out_d     = e_new;
                        ovf_d       = ov;
                        n_d         = res[WIDTH-1];
                        z_d         = (res == '0);
                        done_d      = 1'b1;
                    end
                end
            end
            MUL_RUN: begin
                // Add multiplicand into the high half when the current multiplier bit is set, then shift right.
                sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                          (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
                prod_nx = {sum, prod_q[WIDTH-1:1]};
                prod_d  = prod_nx;
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    result_d    = prod_nx[WIDTH-1:0];
                    result_hi_d = prod_nx[2*WIDTH-1:WIDTH];
                    e_out_d     = e_q;
                    ovf_d       = |prod_nx[2*WIDTH-1:WIDTH];
                    n_d         = prod_nx[WIDTH-1];
                    z_d         = (prod_nx[WIDTH-1:0] == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            e_q         <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            e_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            e_q         <= e_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            e_out_q     <= e_out_d;
            ovf_q       <= ovf_d;
            n_q         <= n_d;
            z_q         <= z_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.e_out     = e_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.n         = n_q;
    assign bus.z         = z_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu with hand-computed expectations.
module tb_seq_alu;
    localparam int W = 16;
    localparam logic [2:0] ADD = 3'b000, AND_ = 3'b001, LDA = 3'b010, CMA = 3'b011,
                           CIR = 3'b100, CIL = 3'b101, INC = 3'b110, MUL = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [15:0] r, input logic [15:0] hi,
                             input logic e, input logic o, input logic nn, input logic zz);
        check({tag, ".result"},    32'(bus.result),    32'(r));
        check({tag, ".result_hi"}, 32'(bus.result_hi), 32'(hi));
        check({tag, ".e_out"},     32'(bus.e_out),     32'(e));
        check({tag, ".ovf"},       32'(bus.ovf),       32'(o));
        check({tag, ".n"},         32'(bus.n),         32'(nn));
        check({tag, ".z"},         32'(bus.z),         32'(zz));
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d, input logic e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.ac    = a;
        bus.dr    = d;
        bus.e_in  = e;
    endtask

    // Single-cycle op: drive at a falling edge, observe after the accept edge.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] d, input logic e);
        @(negedge clk);
        drive(op, a, d, e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.ac = 16'hDEAD;
        bus.dr = 16'hBEEF;
        check({tag, ".done"}, 32'(bus.done), 32'd1);
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int cyc, busy_cnt, dones;
        bus.start = 1'b0; bus.op = 3'b000; bus.ac = '0; bus.dr = '0; bus.e_in = 1'b0;
        repeat (3) @(negedge clk);
        check_out("reset", 16'h0000, 16'h0000, 0, 0, 0, 0);
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        do_op("add_ovf", ADD, 16'h7FFF, 16'h0001, 1'b0);
        check_out("add_ovf", 16'h8000, 16'h0000, 0, 1, 1, 0);
        @(negedge clk);
        check("add_ovf.done_drop", 32'(bus.done), 32'd0);
        check("add_ovf.hold", 32'(bus.result), 32'h8000);

        do_op("add_wrap", ADD, 16'hFFFF, 16'h0001, 1'b0);
        check_out("add_wrap", 16'h0000, 16'h0000, 1, 0, 0, 1);
        do_op("inc_wrap", INC, 16'hFFFF, 16'h0000, 1'b0);
        check_out("inc_wrap", 16'h0000, 16'h0000, 1, 0, 0, 1);
        do_op("inc_max", INC, 16'h7FFF, 16'h0000, 1'b1);
        check_out("inc_max", 16'h8000, 16'h0000, 0, 1, 1, 0);
        do_op("cir", CIR, 16'h0001, 16'h0000, 1'b0);
        check_out("cir", 16'h0000, 16'h0000, 1, 0, 0, 1);
        do_op("cil", CIL, 16'h8000, 16'h0000, 1'b1);
        check_out("cil", 16'h0001, 16'h0000, 1, 0, 0, 0);
        do_op("cma", CMA, 16'h00FF, 16'h1234, 1'b0);
        check_out("cma", 16'hFF00, 16'h0000, 0, 0, 1, 0);
        do_op("and", AND_, 16'h0F0F, 16'h00FF, 1'b1);
        check_out("and", 16'h000F, 16'h0000, 1, 0, 0, 0);

        // MUL with ADD start pulses sprinkled into the busy window.
        @(negedge clk);
        drive(MUL, 16'h0123, 16'h0100, 1'b1);
        @(negedge clk);
        bus.start = 1'b0; bus.ac = 16'hFFFF; bus.dr = 16'hFFFF; bus.e_in = 1'b0;
        check("mul.busy0", 32'(bus.busy), 32'd1);
        check("mul.hold", 32'(bus.result), 32'h000F);
        cyc = 0; busy_cnt = 0;
        while (!bus.done && cyc < 100) begin
            if (bus.busy) busy_cnt++;
            bus.start = (cyc == 3 || cyc == 8);
            bus.op    = ADD;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check("mul.latency", 32'(cyc), 32'd16);
        check("mul.busy_cycles", 32'(busy_cnt), 32'd16);
        check("mul.busy_end", 32'(bus.busy), 32'd0);
        check_out("mul", 16'h2300, 16'h0001, 1, 1, 0, 0);
        dones = 0;
        repeat (5) begin @(negedge clk); if (bus.done) dones++; end
        check("mul.extra_done", 32'(dones), 32'd0);

        // Back-to-back: reassert start in the done cycle.
        @(negedge clk);
        drive(LDA, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        check("lda.done", 32'(bus.done), 32'd1);
        check_out("lda", 16'h0000, 16'h0000, 0, 0, 0, 1);
        drive(LDA, 16'h0000, 16'h1234, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b.done", 32'(bus.done), 32'd1);
        check_out("b2b", 16'h1234, 16'h0000, 1, 0, 0, 0);

        // Reset mid-multiply aborts with no done.
        @(negedge clk);
        drive(MUL, 16'h0123, 16'h0100, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check_out("abort", 16'h0000, 16'h0000, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (20) begin @(negedge clk); if (bus.done || bus.busy) dones++; end
        check("abort.no_done", 32'(dones), 32'd0);
        do_op("add_post", ADD, 16'h0002, 16'h0003, 1'b0);
        check_out("add_post", 16'h0005, 16'h0000, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, clocked successor to the basic-computer combinational ALU. It executes the accumulator-register instruction set (add, and, transfer, complement, circulate through E, increment) in one cycle and unsigned multiply in WIDTH cycles, behind a start/busy/done handshake. Results and flags are registered and held until the next accepted operation. The block sits between the AC/DR/E registers and the control sequencer, which writes result and e_out back on done.

## Interface
- WIDTH, 16: operand/result width in bits; must be at least 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only on a rising edge where busy=0.
- op  in  3  000 ADD, 001 AND, 010 LDA (transfer DR), 011 CMA, 100 CIR, 101 CIL, 110 INC, 111 MUL.
- ac  in  WIDTH  accumulator operand.
- dr  in  WIDTH  data-register operand.
- e_in  in  1  current E flip-flop.
- result  out  WIDTH  registered result; for MUL, the low half of the product.
- result_hi  out  WIDTH  high half of the product; 0 for all non-MUL ops.
- e_out  out  1  new E value.
- ovf  out  1  overflow flag.
- n  out  1  negative flag, equal to result[WIDTH-1].
- z  out  1  zero flag, equal to (result==0).
- busy  out  1  high while a MUL is iterating.
- done  out  1  one-cycle pulse when outputs update.

## Operation
- States: IDLE and MUL_RUN. Reset forces IDLE. Reset drives result, result_hi, e_out, ovf, n, z, busy and done to 0, and clears the iteration counter.
- On accept, ac, dr, e_in and op are captured. Input changes after the accept edge have no effect.
- ADD: {e_out,result} = ac+dr, evaluated at WIDTH+1 bits. ovf is signed overflow: both operand msbs equal and the result msb differs from them.
- AND: result = ac&dr; e_out = e_in; ovf = 0.
- LDA: result = dr; e_out = e_in; ovf = 0.
- CMA: result = ~ac, a full bitwise complement; e_out = e_in; ovf = 0.
- CIR: result = {e_in, ac[WIDTH-1:1]}; e_out = ac[0]; ovf = 0.
- CIL: result = {ac[WIDTH-2:0], e_in}; e_out = ac[WIDTH-1]; ovf = 0.
- INC: {e_out,result} = ac+1. ovf is set when ac = 0 followed by WIDTH-1 ones (the most positive signed value).
- MUL: unsigned shift-add, one multiplier bit per cycle, LSB first. {result_hi,result} = ac*dr; e_out = e_in; ovf = |result_hi.
- n and z are always derived from result only, never from result_hi.
- In IDLE, start=1 with a non-MUL op: outputs update on the accept edge, done=1 for the following cycle, busy stays 0, and the block remains in IDLE.
- In IDLE, start=1 with op=MUL: go to MUL_RUN, busy=1, counter = WIDTH. Outputs keep their previous values during iteration.
- MUL_RUN: each edge performs one iteration and decrements the counter. On the edge where the counter reaches 0, the block writes the outputs, pulses done, clears busy and returns to IDLE.
- start while busy=1 is ignored and not queued.
- Outputs hold between operations; done is 0 except for its one-cycle pulse.

## Timing
- Non-MUL latency: 1 cycle. The accept edge registers the result, and done is high for exactly one cycle after it.
- MUL latency: WIDTH cycles. busy is high for WIDTH cycles starting after the accept edge. done and the final outputs appear after edge WIDTH, with the accept edge counted as edge 0.
- Back-to-back: start may be reasserted in the cycle where done=1, because busy=0 then. That edge is accepted and gives a new done on the next cycle.
- Reset during MUL_RUN: aborts immediately and asynchronously; busy=0, all outputs 0, and no done pulse.
- Reset asserted together with start: reset wins.

## Test plan
- ADD ac=0x7FFF, dr=0x0001, e_in=0 -> result=0x8000, e_out=0, ovf=1, n=1, z=0; done high exactly one cycle after accept.
- ADD ac=0xFFFF, dr=0x0001 -> result=0x0000, e_out=1, ovf=0, z=1. Then INC ac=0xFFFF -> the same result and flags.
- CIR ac=0x0001, e_in=0 -> result=0x0000, e_out=1, z=1. CIL ac=0x8000, e_in=1 -> result=0x0001, e_out=1.
- CMA ac=0x00FF -> result=0xFF00, n=1, ovf=0. LDA dr=0x0000 -> z=1, result_hi=0.
- MUL ac=0x0123, dr=0x0100 -> busy for 16 cycles, then result=0x2300, result_hi=0x0001, ovf=1; start pulses with op=ADD during busy produce no extra done.
- MUL started, rst pulsed 5 cycles after accept -> busy=0, all outputs 0, and no done in the following 20 cycles. The next ADD 0x0002+0x0003 -> result=0x0005.
